// File: rtl/alu_pkg.sv
// Shared opcode map, signed range helpers and the round/saturate arithmetic
// used by the pipelined fixed-point ALU.
package alu_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_MAC  = 3;
    localparam int OP_CLR  = 4;
    localparam int OP_NAND = 5;
    localparam int OP_XNOR = 6;
    localparam int OP_SIGM = 7;
    localparam int OP_ROTL = 8;
    localparam int OP_MIN  = 9;
    localparam int OP_MAX  = 10;
    localparam int OP_ABS  = 11;

    localparam int DEF_INT_W  = 4;
    localparam int DEF_FRAC_W = 6;

    // All helpers work on a 64-bit signed carrier; callers sign-extend in and truncate out.
    function automatic logic signed [63:0] smax(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int unsigned        w);
        if (x > smax(w)) return smax(w);
        if (x < smin(w)) return smin(w);
        return x;
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int unsigned        f);
        return (x + (64'sd1 <<< (f - 1))) >>> f;
    endfunction

endpackage

// File: rtl/alu_sat_round.sv
// Wide signed value -> round half up, drop FRAC_W fraction bits, clamp to OUT_W.
// Shared by the MUL and MAC result paths.
module alu_sat_round
    import alu_pkg::*;
#(
    parameter int IN_W   = 22,
    parameter int FRAC_W = 6,
    parameter int OUT_W  = 10
)(
    input  logic signed [IN_W-1:0]  data_i,
    output logic        [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    logic signed [63:0] wide;
    logic signed [63:0] rnd;
    logic signed [63:0] clp;

    always_comb begin
        wide   = 64'(data_i);
        rnd    = round_shift(wide, FRAC_W);
        clp    = sat_clip(rnd, OUT_W);
        data_o = clp[OUT_W-1:0];
        sat_o  = (clp != rnd);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage signed fixed-point ALU with valid/ready on both sides, an internal
// MAC accumulator and saturation reporting. S1 holds operands, S2 holds results.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int INT_W  = DEF_INT_W,
    parameter  int FRAC_W = DEF_FRAC_W,
    parameter  int INST_W = 4,
    localparam int DATA_W = INT_W + FRAC_W
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 2;
    localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic              s1_valid_q;
    logic [INST_W-1:0] s1_inst_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] o_data_q;
    logic              o_sat_q;
    logic signed [ACC_W-1:0] acc_q;

    logic s1_adv;
    logic s2_adv;
    int   op;

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [63:0]       acc_sum;
    logic signed [ACC_W-1:0]  sr_in;
    logic [DATA_W-1:0]        sr_out;
    logic                     sr_sat;

    logic [DATA_W-1:0] res_d;
    logic              sat_d;
    logic signed [63:0] a_w;
    logic signed [63:0] b_w;
    logic signed [63:0] ar_w;
    logic signed [63:0] clip_w;
    logic signed [63:0] sig_w;
    logic [31:0]         rot_amt;
    logic [2*DATA_W-1:0] rot_w;

    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_ready = s1_adv && !i_rst;
    assign o_valid = s2_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;

    assign op      = int'(s1_inst_q);
    assign a_s     = s1_a_q;
    assign b_s     = s1_b_q;
    assign prod    = a_s * b_s;
    assign acc_sum = sat_clip(64'(acc_q) + 64'(prod), ACC_W);
    // MAC rounds the updated accumulator; MUL rounds the bare product.
    assign sr_in   = (op == OP_MAC) ? ACC_W'(acc_sum) : ACC_W'(prod);

    alu_sat_round #(
        .IN_W  (ACC_W),
        .FRAC_W(FRAC_W),
        .OUT_W (DATA_W)
    ) u_sat_round (
        .data_i(sr_in),
        .data_o(sr_out),
        .sat_o (sr_sat)
    );

    always_comb begin
        res_d   = '0;
        sat_d   = 1'b0;
        a_w     = 64'(a_s);
        b_w     = 64'(b_s);
        ar_w    = '0;
        clip_w  = '0;
        sig_w   = '0;
        rot_amt = 32'(s1_b_q) % 32'(DATA_W);
        rot_w   = {s1_a_q, s1_a_q} << rot_amt;
        case (op)
            OP_ADD, OP_SUB: begin
                ar_w   = (op == OP_ADD) ? (a_w + b_w) : (a_w - b_w);
                clip_w = sat_clip(ar_w, DATA_W);
                res_d  = clip_w[DATA_W-1:0];
                sat_d  = (clip_w != ar_w);
            end
            OP_MUL, OP_MAC: begin
                res_d = sr_out;
                sat_d = sr_sat;
            end
            OP_NAND: res_d = ~(s1_a_q & s1_b_q);
            OP_XNOR: res_d = ~(s1_a_q ^ s1_b_q);
            OP_SIGM: begin
                // Clip to [0, 1.0] is part of the transfer function, not a saturation.
                sig_w = (a_w >>> 2) + (64'sd1 <<< (FRAC_W - 1));
                if (sig_w < 64'sd0)
                    sig_w = 64'sd0;
                else if (sig_w > (64'sd1 <<< FRAC_W))
                    sig_w = 64'sd1 <<< FRAC_W;
                res_d = sig_w[DATA_W-1:0];
            end
            OP_ROTL: res_d = rot_w[2*DATA_W-1:DATA_W];
            OP_MIN:  res_d = (a_s < b_s) ? s1_a_q : s1_b_q;
            OP_MAX:  res_d = (a_s > b_s) ? s1_a_q : s1_b_q;
            OP_ABS: begin
                if (s1_a_q == D_MIN) begin
                    res_d = D_MAX;
                    sat_d = 1'b1;
                end else begin
                    res_d = a_s[DATA_W-1] ? DATA_W'(-a_w) : s1_a_q;
                end
            end
            default: begin
                res_d = '0;
                sat_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    s1_inst_q <= i_inst;
                    s1_a_q    <= i_data_a;
                    s1_b_q    <= i_data_b;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    o_data_q <= res_d;
                    o_sat_q  <= sat_d;
                    // Accumulator moves only on the S1->S2 transfer, so a stalled MAC counts once.
                    if (op == OP_MAC)
                        acc_q <= ACC_W'(acc_sum);
                    else if (op == OP_CLR)
                        acc_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: the driver queues hand-computed results and an
// independent monitor compares every presented beat against the queue head.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [9:0] d;
        logic       s;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_inst;
    logic [9:0] i_data_a;
    logic [9:0] i_data_b;
    logic       o_valid;
    logic       i_ready;
    logic [9:0] o_data;
    logic       o_sat;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_acc    = 0;

    alu_pipe #(.INT_W(4), .FRAC_W(6), .INST_W(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_inst  (i_inst),
        .i_data_a(i_data_a),
        .i_data_b(i_data_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input int op, input logic [9:0] a,
                         input logic [9:0] b, input logic [9:0] ed, input logic es,
                         input bit track);
        int guard;
        i_valid  = 1'b1;
        i_inst   = 4'(op);
        i_data_a = a;
        i_data_b = b;
        guard    = 0;
        @(negedge clk);
        while (!o_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!o_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_accept: o_ready stayed 0 for %0d cycles", nm, guard);
        end else if (track) begin
            sb_q.push_back('{ed, es, nm});
        end
        @(posedge clk);
        #1;
        if (guard < 50) n_acc++;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            guard++;
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d results still outstanding", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every cycle o_valid is up, popping only on transfer,
    // so a stalled beat is re-checked against the same expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_beat: got data %0h with nothing expected", o_data);
            end else begin
                e = sb_q[0];
                check({e.nm, "_data"}, 32'(o_data), 32'(e.d));
                check({e.nm, "_sat"},  32'(o_sat),  32'(e.s));
                if (i_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_inst   = '0;
        i_data_a = '0;
        i_data_b = '0;
        i_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_ready", 32'(o_ready), 32'd0);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_sat",   32'(o_sat),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_o_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: result appears on the second cycle after acceptance.
        issue("add_sat", OP_ADD, 10'h1C0, 10'h080, 10'h1FF, 1'b1, 1);
        @(negedge clk);
        check("lat_cycle1_o_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_o_valid", 32'(o_valid), 32'd1);
        drain();

        issue("sub_min",  OP_SUB,  10'h000, 10'h200, 10'h1FF, 1'b1, 1);
        issue("mul_neg",  OP_MUL,  10'h060, 10'h3A0, 10'h370, 1'b0, 1);
        issue("mul_rnd",  OP_MUL,  10'h001, 10'h020, 10'h001, 1'b0, 1);
        issue("clr",      OP_CLR,  10'h123, 10'h045, 10'h000, 1'b0, 1);
        issue("mac1",     OP_MAC,  10'h040, 10'h080, 10'h080, 1'b0, 1);
        issue("mac2",     OP_MAC,  10'h040, 10'h080, 10'h100, 1'b0, 1);
        issue("mac3",     OP_MAC,  10'h040, 10'h080, 10'h180, 1'b0, 1);
        issue("mac4_sat", OP_MAC,  10'h040, 10'h080, 10'h1FF, 1'b1, 1);
        issue("rotl",     OP_ROTL, 10'h001, 10'h00B, 10'h002, 1'b0, 1);
        issue("sigm_0",   OP_SIGM, 10'h000, 10'h000, 10'h020, 1'b0, 1);
        issue("sigm_hi",  OP_SIGM, 10'h180, 10'h000, 10'h040, 1'b0, 1);
        issue("sigm_lo",  OP_SIGM, 10'h200, 10'h000, 10'h000, 1'b0, 1);
        issue("abs_min",  OP_ABS,  10'h200, 10'h000, 10'h1FF, 1'b1, 1);
        issue("abs_neg",  OP_ABS,  10'h3C0, 10'h000, 10'h040, 1'b0, 1);
        issue("nand",     OP_NAND, 10'h0F0, 10'h3CC, 10'h33F, 1'b0, 1);
        issue("xnor",     OP_XNOR, 10'h0F0, 10'h3CC, 10'h0C3, 1'b0, 1);
        issue("min",      OP_MIN,  10'h100, 10'h380, 10'h380, 1'b0, 1);
        issue("max",      OP_MAX,  10'h100, 10'h380, 10'h100, 1'b0, 1);
        issue("add_nsat", OP_ADD,  10'h200, 10'h3FF, 10'h200, 1'b1, 1);
        issue("add_plain",OP_ADD,  10'h010, 10'h020, 10'h030, 1'b0, 1);
        issue("undef_op", 15,      10'h155, 10'h0AA, 10'h000, 1'b0, 1);
        drain();

        // Backpressure: two beats fill the stages, then o_ready must drop.
        i_ready = 1'b0;
        n_acc   = 0;
        fork
            begin
                issue("bp1", OP_ADD, 10'h001, 10'h001, 10'h002, 1'b0, 1);
                issue("bp2", OP_ADD, 10'h002, 10'h002, 10'h004, 1'b0, 1);
                issue("bp3", OP_SUB, 10'h010, 10'h001, 10'h00F, 1'b0, 1);
                issue("bp4", OP_MIN, 10'h005, 10'h3FF, 10'h3FF, 1'b0, 1);
                issue("bp5", OP_MAX, 10'h005, 10'h3FF, 10'h005, 1'b0, 1);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_o_ready_low", 32'(o_ready), 32'd0);
                check("bp_accepts",     32'(n_acc),   32'd2);
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight: both discarded, accumulator cleared.
        issue("flight1", OP_ADD, 10'h011, 10'h022, 10'h000, 1'b0, 0);
        issue("flight2", OP_MAC, 10'h040, 10'h040, 10'h000, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_o_valid", 32'(o_valid), 32'd0);
        check("post_rst_o_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        issue("mac_after_rst", OP_MAC, 10'h040, 10'h040, 10'h040, 1'b0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
